commit_monitor: RTL and testbench
=================================

Name: commit_monitor

Overview:
- Parametrised retire/commit tracker that sits between the core's writeback stage(s) and the Difftest commit, trap and counter hooks.
- Generalises the single-lane commit registers to COMMIT_WIDTH lanes.
- Adds in-order lane checking, trap squash of younger lanes, first-commit-only skip, and halt states.
- Adds a no-commit watchdog.

Parameters:
- COMMIT_WIDTH, 2: number of retire lanes (1..4); lane 0 is oldest.
- XLEN, 64: data and PC width.
- PC_START, 64'h8000_0000: reset PC; the first commit at this PC is skipped.
- TRAP_OPCODE, 7'h6b: inst[6:0] value that marks the halt trap instruction.
- TIMEOUT_CYCLES, 5000: consecutive zero-commit cycles that trigger a timeout halt.

Ports:
- clock  in  1  clock
- reset  in  1  reset, synchronous, active-high
- rt_valid  in  COMMIT_WIDTH  lane retires this cycle
- rt_pc  in  COMMIT_WIDTH*XLEN  lane PC, flattened, lane i at [i*XLEN +: XLEN]
- rt_inst  in  COMMIT_WIDTH*32  lane instruction
- rt_wen  in  COMMIT_WIDTH  lane writes rd
- rt_wdest  in  COMMIT_WIDTH*5  lane rd index
- rt_wdata  in  COMMIT_WIDTH*XLEN  lane rd write data
- rt_skip  in  COMMIT_WIDTH  lane requests difftest skip (MMIO etc.)
- a0_data  in  XLEN  architectural x10 value, used as the trap code
- cmt_valid  out  COMMIT_WIDTH  registered committed lanes
- cmt_pc, cmt_inst, cmt_wdata  out  lane-flattened  registered copies of the lane inputs
- cmt_wen  out  COMMIT_WIDTH  registered write-enable per lane
- cmt_wdest  out  COMMIT_WIDTH*8  zero-extended rd index per lane
- cmt_skip  out  COMMIT_WIDTH  registered skip flag per lane
- cycle_cnt  out  64  cycles spent in RUN
- instr_cnt  out  64  committed instruction count
- trap_valid  out  1  halted indicator for the Difftest trap event
- trap_code  out  8  halt code
- trap_pc  out  XLEN  PC of the trap instruction
- order_err  out  1  sticky lane-order violation flag
- idle_cnt  out  64  zero-commit cycles counter (see Optional Feature)

Behaviour:
- Reset: every output is 0; state is RUN; the first_done flag is cleared.
- Latency: 1 cycle. Lane inputs in cycle N appear on cmt_* in cycle N+1. When nothing is committed, cmt_valid is 0 and the other cmt_* fields hold their previous values.
- Lane order rule: rt_valid must be a contiguous run starting at lane 0. On violation:
  - order_err is set and stays set until reset;
  - only the contiguous prefix of lanes is committed.
- Effective mask: contiguous prefix, additionally truncated at the first lane whose inst[6:0] equals TRAP_OPCODE. That trap lane is committed; all younger lanes are squashed.
- Write-enable: cmt_wen[i] = rt_wen[i] && wdest != 0 && lane committed.
- Skip: cmt_skip[i] = rt_skip[i] OR (first_done==0 AND pc==PC_START AND lane i is the oldest committed lane). first_done is set after the first cycle with any commit, so only the first fetch of PC_START is skipped.
- State RUN:
  - cycle_cnt increments by 1 every cycle, wrapping mod 2^64;
  - instr_cnt increments by the popcount of the effective mask;
  - idle counter resets on any commit, else increments.
- RUN -> HALT_TRAP when a trap lane commits.
  - Next cycle: trap_valid=1, trap_code=a0_data[7:0], trap_pc=the trap lane's PC.
  - Counters include the trap cycle and the trap instruction.
- RUN -> HALT_TIMEOUT when the idle counter reaches TIMEOUT_CYCLES-1 and there is no commit this cycle.
  - Next cycle: trap_valid=1, trap_code=8'hff, trap_pc=last committed PC (0 if none).
- A trap commit in the same cycle as the timeout threshold goes to HALT_TRAP; the commit clears the idle condition.
- HALT_* states:
  - absorbing; only reset leaves them;
  - rt_valid is ignored and cmt_valid=0;
  - counters freeze; trap_valid stays 1.
- Reset in any state, including mid-trap, returns to the reset values in the next cycle.

Optional Feature:
- Macro: COMMIT_MONITOR_PERF_EN.
- Defined: idle_cnt counts total RUN cycles with zero commits, 64-bit and wrapping. It is frozen in HALT_* states.
- Undefined: idle_cnt is tied to 0 and its counter is not synthesised. The watchdog still works, because it uses its own run-length counter.

Decomposition:
- Shared package (commit_pkg):
  - PC_START and TRAP_OPCODE constants;
  - state enum {RUN, HALT_TRAP, HALT_TIMEOUT};
  - commit-lane record typedef (valid, pc, inst, wen, wdest, wdata, skip);
  - TIMEOUT_CODE = 8'hff.
- Sub-module commit_lane_mask (combinational): computes the effective mask, order_err_now and trap_lane index from rt_valid and the opcodes.
- Top: lane registers, counters and state machine.

Test Plan:
- Reset, then lanes {1,1} at pc 0x80000000/0x80000004 with x5 and x6 writes -> next cycle:
  - cmt_valid=2'b11, cmt_skip=2'b01, instr_cnt=2;
  - first_done is set, and a later commit at 0x80000000 has skip=0.
- rt_valid=2'b10 -> cmt_valid=0, order_err=1 and sticky; instr_cnt unchanged.
- Lane 0 inst opcode 0x6b, a0=0, lane 1 valid -> lane 1 squashed:
  - trap_valid=1, trap_code=0, trap_pc=lane 0 PC;
  - counters frozen thereafter.
- No commits for TIMEOUT_CYCLES (5000) cycles -> trap_valid=1, trap_code=8'hff.
  - A commit arriving at cycle 4999 resets the idle counter and prevents the timeout.
- rt_wen=1 with wdest=0 -> cmt_wen=0. Reset asserted mid HALT_TRAP -> all outputs 0 and state RUN next cycle.
- With COMMIT_MONITOR_PERF_EN: 3 idle cycles out of 10 -> idle_cnt=3. Without the macro -> idle_cnt=0.

Source files
------------

// File: rtl/commit_monitor_pkg.sv
// +----------------------------------------------------------------------------+
// | commit_monitor_pkg : shared constants, FSM states and lane record for the  |
// |                      commit monitor slice                                  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package commit_monitor_pkg;

  localparam logic [63:0] PC_START_DEFAULT    = 64'h8000_0000;
  localparam logic [6:0]  TRAP_OPCODE_DEFAULT = 7'h6b;
  localparam logic [7:0]  TIMEOUT_CODE        = 8'hff;
  localparam int          MAX_LANES           = 4;

  localparam logic [1:0] ST_RUN          = 2'd0;
  localparam logic [1:0] ST_HALT_TRAP    = 2'd1;
  localparam logic [1:0] ST_HALT_TIMEOUT = 2'd2;

  // pc/wdata are held at the widest supported XLEN
  typedef struct packed {
    logic        valid;
    logic [63:0] pc;
    logic [31:0] inst;
    logic        wen;
    logic [4:0]  wdest;
    logic [63:0] wdata;
    logic        skip;
  } commit_lane_t;

  function automatic logic [63:0] count_ones(input logic [MAX_LANES-1:0] m);
    logic [63:0] n;
    n = '0;
    for (int i = 0; i < MAX_LANES; i++) begin
      n = n + {63'd0, m[i]};
    end
    return n;
  endfunction

endpackage

`default_nettype wire

// File: rtl/commit_monitor_lane_mask.sv
// +----------------------------------------------------------------------------+
// | commit_monitor_lane_mask : contiguous-prefix and trap-squash lane masking  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module commit_monitor_lane_mask
  import commit_monitor_pkg::*;
#(
  parameter int         COMMIT_WIDTH = 2,
  parameter logic [6:0] TRAP_OPCODE  = TRAP_OPCODE_DEFAULT
) (
  input  logic [COMMIT_WIDTH-1:0]      valid_i,
  input  logic [COMMIT_WIDTH*7-1:0]    opcode_i,
  output logic [COMMIT_WIDTH-1:0]      mask_o,
  output logic                         order_err_now_o,
  output logic                         trap_hit_o,
  output logic [$clog2(MAX_LANES)-1:0] trap_lane_o
);

  logic [COMMIT_WIDTH-1:0] prefix;

  always_comb begin
    prefix      = '0;
    mask_o      = '0;
    trap_hit_o  = 1'b0;
    trap_lane_o = '0;
    prefix[0]   = valid_i[0];
    for (int i = 1; i < COMMIT_WIDTH; i++) begin
      prefix[i] = prefix[i-1] & valid_i[i];
    end
    order_err_now_o = |(valid_i & ~prefix);
    // the oldest trap lane still commits; everything younger is dropped
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      if (prefix[i] && !trap_hit_o) begin
        mask_o[i] = 1'b1;
        if (opcode_i[i*7 +: 7] == TRAP_OPCODE) begin
          trap_hit_o  = 1'b1;
          trap_lane_o = ($clog2(MAX_LANES))'(i);
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/commit_monitor.sv
// +----------------------------------------------------------------------------+
// | commit_monitor : multi-lane retire tracker feeding commit/trap/counters.   |
// | Optional macro COMMIT_MONITOR_PERF_EN enables the idle_cnt_o counter.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module commit_monitor
  import commit_monitor_pkg::*;
#(
  parameter int          COMMIT_WIDTH   = 2,
  parameter int          XLEN           = 64,
  parameter logic [63:0] PC_START       = PC_START_DEFAULT,
  parameter logic [6:0]  TRAP_OPCODE    = TRAP_OPCODE_DEFAULT,
  parameter int          TIMEOUT_CYCLES = 5000
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [COMMIT_WIDTH-1:0]      rt_valid_i,
  input  logic [COMMIT_WIDTH*XLEN-1:0] rt_pc_i,
  input  logic [COMMIT_WIDTH*32-1:0]   rt_inst_i,
  input  logic [COMMIT_WIDTH-1:0]      rt_wen_i,
  input  logic [COMMIT_WIDTH*5-1:0]    rt_wdest_i,
  input  logic [COMMIT_WIDTH*XLEN-1:0] rt_wdata_i,
  input  logic [COMMIT_WIDTH-1:0]      rt_skip_i,
  input  logic [XLEN-1:0]              a0_data_i,
  output logic [COMMIT_WIDTH-1:0]      cmt_valid_o,
  output logic [COMMIT_WIDTH*XLEN-1:0] cmt_pc_o,
  output logic [COMMIT_WIDTH*32-1:0]   cmt_inst_o,
  output logic [COMMIT_WIDTH*XLEN-1:0] cmt_wdata_o,
  output logic [COMMIT_WIDTH-1:0]      cmt_wen_o,
  output logic [COMMIT_WIDTH*8-1:0]    cmt_wdest_o,
  output logic [COMMIT_WIDTH-1:0]      cmt_skip_o,
  output logic [63:0]                  cycle_cnt_o,
  output logic [63:0]                  instr_cnt_o,
  output logic                         trap_valid_o,
  output logic [7:0]                   trap_code_o,
  output logic [XLEN-1:0]              trap_pc_o,
  output logic                         order_err_o,
  output logic [63:0]                  idle_cnt_o
);

  localparam int              RUN_W      = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [RUN_W-1:0] IDLE_LIMIT = RUN_W'(TIMEOUT_CYCLES - 1);

  logic [COMMIT_WIDTH-1:0]      mask;
  logic [COMMIT_WIDTH*7-1:0]    opcodes;
  logic                         order_err_now;
  logic                         trap_hit;
  logic [$clog2(MAX_LANES)-1:0] trap_lane;
  logic                         running;
  logic                         any_commit;
  logic                         unused_a0;

  logic [1:0]       state_q, state_d;
  logic             first_done_q;
  logic [63:0]      cycle_q, cycle_d;
  logic [63:0]      instr_q, instr_d;
  logic [RUN_W-1:0] run_len_q, run_len_d;
  logic             trap_valid_q, trap_valid_d;
  logic [7:0]       trap_code_q, trap_code_d;
  logic [XLEN-1:0]  trap_pc_q, trap_pc_d;
  logic [XLEN-1:0]  last_pc_q, last_pc_d;
  logic [XLEN-1:0]  trap_pc_sel;
  logic             order_err_q, order_err_d;

  assign running    = (state_q == ST_RUN);
  assign any_commit = running && (|mask);
  assign unused_a0  = ^a0_data_i[XLEN-1:8];

  commit_monitor_lane_mask #(
    .COMMIT_WIDTH (COMMIT_WIDTH),
    .TRAP_OPCODE  (TRAP_OPCODE)
  ) u_lane_mask (
    .valid_i         (rt_valid_i),
    .opcode_i        (opcodes),
    .mask_o          (mask),
    .order_err_now_o (order_err_now),
    .trap_hit_o      (trap_hit),
    .trap_lane_o     (trap_lane)
  );

  generate
    for (genvar i = 0; i < COMMIT_WIDTH; i++) begin : g_lane
      commit_lane_t lane_d, lane_q;
      logic [63:0]  lane_pc;

      assign opcodes[i*7 +: 7] = rt_inst_i[i*32 +: 7];
      assign lane_pc           = 64'(rt_pc_i[i*XLEN +: XLEN]);

      always_comb begin
        lane_d       = lane_q;
        lane_d.valid = 1'b0;
        if (running && mask[i]) begin
          lane_d.valid = 1'b1;
          lane_d.pc    = lane_pc;
          lane_d.inst  = rt_inst_i[i*32 +: 32];
          lane_d.wen   = rt_wen_i[i] && (rt_wdest_i[i*5 +: 5] != 5'd0);
          lane_d.wdest = rt_wdest_i[i*5 +: 5];
          lane_d.wdata = 64'(rt_wdata_i[i*XLEN +: XLEN]);
          // lane 0 is always the oldest committed lane of a contiguous mask
          lane_d.skip  = rt_skip_i[i] |
                         ((i == 0) && !first_done_q && (lane_pc == PC_START));
        end
      end

      always_ff @(posedge clock) begin
        if (reset) lane_q <= '0;
        else       lane_q <= lane_d;
      end

      assign cmt_valid_o[i]             = lane_q.valid;
      assign cmt_pc_o[i*XLEN +: XLEN]   = lane_q.pc[XLEN-1:0];
      assign cmt_inst_o[i*32 +: 32]     = lane_q.inst;
      assign cmt_wdata_o[i*XLEN +: XLEN] = lane_q.wdata[XLEN-1:0];
      assign cmt_wen_o[i]               = lane_q.wen;
      assign cmt_wdest_o[i*8 +: 8]      = {3'b000, lane_q.wdest};
      assign cmt_skip_o[i]              = lane_q.skip;
    end
  endgenerate

  always_comb begin
    trap_pc_sel = '0;
    last_pc_d   = last_pc_q;
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      if (running && mask[i]) last_pc_d = rt_pc_i[i*XLEN +: XLEN];
      if (trap_lane == ($clog2(MAX_LANES))'(i)) trap_pc_sel = rt_pc_i[i*XLEN +: XLEN];
    end
  end

  always_comb begin
    state_d      = state_q;
    cycle_d      = cycle_q;
    instr_d      = instr_q;
    run_len_d    = run_len_q;
    trap_valid_d = trap_valid_q;
    trap_code_d  = trap_code_q;
    trap_pc_d    = trap_pc_q;
    order_err_d  = order_err_q;
    if (running) begin
      cycle_d     = cycle_q + 64'd1;
      instr_d     = instr_q + count_ones(MAX_LANES'(mask));
      order_err_d = order_err_q | order_err_now;
      run_len_d   = any_commit ? '0 : run_len_q + 1'b1;
      // a trap commit clears the idle condition, so it wins over the watchdog
      if (trap_hit) begin
        state_d      = ST_HALT_TRAP;
        trap_valid_d = 1'b1;
        trap_code_d  = a0_data_i[7:0];
        trap_pc_d    = trap_pc_sel;
      end else if (!any_commit && (run_len_q == IDLE_LIMIT)) begin
        state_d      = ST_HALT_TIMEOUT;
        trap_valid_d = 1'b1;
        trap_code_d  = TIMEOUT_CODE;
        trap_pc_d    = last_pc_q;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_RUN;
      first_done_q <= 1'b0;
      cycle_q      <= '0;
      instr_q      <= '0;
      run_len_q    <= '0;
      trap_valid_q <= 1'b0;
      trap_code_q  <= '0;
      trap_pc_q    <= '0;
      last_pc_q    <= '0;
      order_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      first_done_q <= first_done_q | any_commit;
      cycle_q      <= cycle_d;
      instr_q      <= instr_d;
      run_len_q    <= run_len_d;
      trap_valid_q <= trap_valid_d;
      trap_code_q  <= trap_code_d;
      trap_pc_q    <= trap_pc_d;
      last_pc_q    <= last_pc_d;
      order_err_q  <= order_err_d;
    end
  end

`ifdef COMMIT_MONITOR_PERF_EN
  logic [63:0] idle_cnt_q;

  always_ff @(posedge clock) begin
    if (reset)                       idle_cnt_q <= '0;
    else if (running && !any_commit) idle_cnt_q <= idle_cnt_q + 64'd1;
  end

  assign idle_cnt_o = idle_cnt_q;
`else
  assign idle_cnt_o = '0;
`endif

  assign cycle_cnt_o  = cycle_q;
  assign instr_cnt_o  = instr_q;
  assign trap_valid_o = trap_valid_q;
  assign trap_code_o  = trap_code_q;
  assign trap_pc_o    = trap_pc_q;
  assign order_err_o  = order_err_q;

endmodule

`default_nettype wire

// File: tb/tb_commit_monitor.sv
// +----------------------------------------------------------------------------+
// | tb_commit_monitor : directed + random bench against a behavioural model.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_commit_monitor;

  localparam int          W   = 2;
  localparam int          X   = 64;
  localparam int          T   = 5000;
  localparam logic [63:0] PCS = 64'h8000_0000;
`ifdef COMMIT_MONITOR_PERF_EN
  localparam logic [63:0] EXP_IDLE3 = 64'd3;
`else
  localparam logic [63:0] EXP_IDLE3 = 64'd0;
`endif

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic [W-1:0]    rt_valid = '0;
  logic [W*X-1:0]  rt_pc = '0;
  logic [W*32-1:0] rt_inst = '0;
  logic [W-1:0]    rt_wen = '0;
  logic [W*5-1:0]  rt_wdest = '0;
  logic [W*X-1:0]  rt_wdata = '0;
  logic [W-1:0]    rt_skip = '0;
  logic [X-1:0]    a0_data = '0;

  logic [W-1:0]    cmt_valid, cmt_wen, cmt_skip;
  logic [W*X-1:0]  cmt_pc, cmt_wdata;
  logic [W*32-1:0] cmt_inst;
  logic [W*8-1:0]  cmt_wdest;
  logic [63:0]     cycle_cnt, instr_cnt, idle_cnt;
  logic            trap_valid, order_err;
  logic [7:0]      trap_code;
  logic [X-1:0]    trap_pc;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  commit_monitor #(
    .COMMIT_WIDTH (W),
    .XLEN         (X)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .rt_valid_i   (rt_valid),
    .rt_pc_i      (rt_pc),
    .rt_inst_i    (rt_inst),
    .rt_wen_i     (rt_wen),
    .rt_wdest_i   (rt_wdest),
    .rt_wdata_i   (rt_wdata),
    .rt_skip_i    (rt_skip),
    .a0_data_i    (a0_data),
    .cmt_valid_o  (cmt_valid),
    .cmt_pc_o     (cmt_pc),
    .cmt_inst_o   (cmt_inst),
    .cmt_wdata_o  (cmt_wdata),
    .cmt_wen_o    (cmt_wen),
    .cmt_wdest_o  (cmt_wdest),
    .cmt_skip_o   (cmt_skip),
    .cycle_cnt_o  (cycle_cnt),
    .instr_cnt_o  (instr_cnt),
    .trap_valid_o (trap_valid),
    .trap_code_o  (trap_code),
    .trap_pc_o    (trap_pc),
    .order_err_o  (order_err),
    .idle_cnt_o   (idle_cnt)
  );

  // reference model: halted mode 0=running, 1=trap, 2=timeout
  logic [W-1:0]    e_valid;
  logic [63:0]     e_pc[W], e_wdata[W];
  logic [31:0]     e_inst[W];
  logic [7:0]      e_wdest[W];
  logic            e_wen[W], e_skip[W];
  longint unsigned e_cycle, e_instr, e_idle;
  int              e_run, e_mode;
  logic            e_first, e_trapv, e_oerr;
  logic [7:0]      e_code;
  logic [63:0]     e_tpc, e_last;

  task automatic model_clock();
    int n, nv, tl;
    bit trap;
    e_valid = '0;
    if (reset) begin
      for (int k = 0; k < W; k++) begin
        e_pc[k] = '0; e_wdata[k] = '0; e_inst[k] = '0; e_wdest[k] = '0;
        e_wen[k] = 1'b0; e_skip[k] = 1'b0;
      end
      e_cycle = 0; e_instr = 0; e_idle = 0; e_run = 0; e_mode = 0;
      e_first = 1'b0; e_trapv = 1'b0; e_oerr = 1'b0; e_code = '0; e_tpc = '0; e_last = '0;
      return;
    end
    if (e_mode != 0) return;
    n = 0;
    while (n < W && rt_valid[n]) n++;
    nv = 0;
    for (int k = 0; k < W; k++) nv += int'(rt_valid[k]);
    if (nv != n) e_oerr = 1'b1;
    trap = 0; tl = 0;
    for (int k = 0; k < n; k++) begin
      if (rt_inst[k*32 +: 7] == 7'h6b) begin
        trap = 1; tl = k; n = k + 1;
        break;
      end
    end
    for (int k = 0; k < n; k++) begin
      e_valid[k] = 1'b1;
      e_pc[k]    = rt_pc[k*X +: X];
      e_inst[k]  = rt_inst[k*32 +: 32];
      e_wdata[k] = rt_wdata[k*X +: X];
      e_wdest[k] = {3'b000, rt_wdest[k*5 +: 5]};
      e_wen[k]   = rt_wen[k] && (rt_wdest[k*5 +: 5] != 0);
      e_skip[k]  = rt_skip[k] || (!e_first && k == 0 && rt_pc[k*X +: X] == PCS);
    end
    e_cycle++;
    e_instr += longint'(n);
    if (n > 0) begin
      e_first = 1'b1;
      e_last  = rt_pc[(n-1)*X +: X];
    end else begin
      e_idle++;
    end
    if (trap) begin
      e_mode = 1; e_trapv = 1'b1; e_code = a0_data[7:0]; e_tpc = rt_pc[tl*X +: X];
    end else if (n == 0 && e_run == T - 1) begin
      e_mode = 2; e_trapv = 1'b1; e_code = 8'hff; e_tpc = e_last;
    end
    if (n > 0) e_run = 0;
    else       e_run++;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [W*X-1:0]  xpc, xwd;
    logic [W*32-1:0] xin;
    logic [W*8-1:0]  xwdst;
    logic [W-1:0]    xwen, xskip;
    for (int k = 0; k < W; k++) begin
      xpc[k*X +: X] = e_pc[k]; xwd[k*X +: X] = e_wdata[k];
      xin[k*32 +: 32] = e_inst[k]; xwdst[k*8 +: 8] = e_wdest[k];
      xwen[k] = e_wen[k]; xskip[k] = e_skip[k];
    end
    chk("cmt_valid", cmt_valid, e_valid);
    chk("cmt_pc", cmt_pc, xpc);
    chk("cmt_inst", cmt_inst, xin);
    chk("cmt_wdata", cmt_wdata, xwd);
    chk("cmt_wen", cmt_wen, xwen);
    chk("cmt_wdest", cmt_wdest, xwdst);
    chk("cmt_skip", cmt_skip, xskip);
    chk("cycle_cnt", cycle_cnt, e_cycle);
    chk("instr_cnt", instr_cnt, e_instr);
    chk("trap_valid", trap_valid, e_trapv);
    chk("trap_code", trap_code, e_code);
    chk("trap_pc", trap_pc, e_tpc);
    chk("order_err", order_err, e_oerr);
`ifdef COMMIT_MONITOR_PERF_EN
    chk("idle_cnt", idle_cnt, e_idle);
`else
    chk("idle_cnt", idle_cnt, 64'd0);
`endif
  endtask

  task automatic step();
    model_clock();
    @(posedge clock);
    #1;
    check_all();
  endtask

  task automatic go_idle();
    rt_valid = '0; rt_wen = '0; rt_skip = '0;
  endtask

  task automatic rand_inputs(input int trap_pct);
    int r;
    r = $urandom_range(0, 9);
    if (r < 2)       rt_valid = '0;
    else if (r == 2) rt_valid = W'($urandom);
    else             rt_valid = ($urandom_range(0, 1) == 0) ? W'(1) : '1;
    for (int k = 0; k < W; k++) begin
      logic [31:0] ins;
      rt_pc[k*X +: X]    = ($urandom_range(0, 7) == 0) ? PCS : {32'd0, $urandom & 32'hffff_fffc};
      ins                = $urandom;
      if (ins[6:0] == 7'h6b) ins[0] = ~ins[0];
      if (int'($urandom_range(0, 99)) < trap_pct) ins[6:0] = 7'h6b;
      rt_inst[k*32 +: 32] = ins;
      rt_wdest[k*5 +: 5]  = 5'($urandom_range(0, 31));
      rt_wdata[k*X +: X]  = {$urandom, $urandom};
    end
    rt_wen  = W'($urandom);
    rt_skip = ($urandom_range(0, 3) == 0) ? W'($urandom) : '0;
    a0_data = {$urandom, $urandom};
  endtask

  initial begin
    reset = 1'b1;
    step();
    step();
    chk("reset_valid", cmt_valid, 0);
    chk("reset_instr", instr_cnt, 0);
    chk("reset_trap", trap_valid, 0);
    reset = 1'b0;

    // two-lane first commit at the reset PC
    rt_valid = 2'b11;
    rt_pc    = {64'h8000_0004, 64'h8000_0000};
    rt_inst  = {32'h0000_0313, 32'h0000_0293};
    rt_wen   = 2'b11;
    rt_wdest = {5'd6, 5'd5};
    rt_wdata = {64'h66, 64'h55};
    step();
    chk("first_valid", cmt_valid, 2'b11);
    chk("first_skip", cmt_skip, 2'b01);
    chk("first_instr", instr_cnt, 64'd2);

    // PC_START again, lane 0 writes x0
    rt_valid        = 2'b01;
    rt_pc[63:0]     = PCS;
    rt_wdest[4:0]   = 5'd0;
    rt_wen          = 2'b01;
    step();
    chk("again_skip", cmt_skip[0], 1'b0);
    chk("x0_wen", cmt_wen[0], 1'b0);

    rt_valid = 2'b10;
    step();
    chk("order_valid", cmt_valid, 2'b00);
    chk("order_err", order_err, 1'b1);
    chk("order_instr", instr_cnt, 64'd3);
    go_idle();
    step();
    chk("order_sticky", order_err, 1'b1);

    repeat (300) begin
      rand_inputs(0);
      step();
    end

    // trap on lane 0 squashes lane 1
    rt_valid = 2'b11;
    rt_pc    = {64'h8000_1004, 64'h8000_1000};
    rt_inst  = {32'h0000_0013, 32'h0000_006b};
    a0_data  = '0;
    step();
    chk("trap_valid", trap_valid, 1'b1);
    chk("trap_code", trap_code, 8'h00);
    chk("trap_pc", trap_pc, 64'h8000_1000);
    chk("trap_squash", cmt_valid, 2'b01);
    repeat (20) begin
      rand_inputs(10);
      step();
    end

    reset = 1'b1;
    step();
    chk("halt_reset_trap", trap_valid, 1'b0);
    chk("halt_reset_cycle", cycle_cnt, 64'd0);
    reset = 1'b0;

    // watchdog: commit on idle cycle 4999 defers the timeout
    go_idle();
    repeat (T - 1) step();
    rt_valid    = 2'b01;
    rt_pc[63:0] = 64'h8000_2000;
    rt_inst     = {32'h0000_0013, 32'h0000_0013};
    step();
    chk("no_timeout", trap_valid, 1'b0);
    go_idle();
    repeat (T) step();
    chk("timeout_valid", trap_valid, 1'b1);
    chk("timeout_code", trap_code, 8'hff);
    chk("timeout_pc", trap_pc, 64'h8000_2000);

    // 3 idle cycles in 10
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      rt_valid = (c == 2 || c == 5 || c == 8) ? 2'b00 : 2'b01;
      step();
    end
    chk("idle_cnt_3", idle_cnt, EXP_IDLE3);

    repeat (400) begin
      reset = ($urandom_range(0, 39) == 0);
      rand_inputs(5);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
